dma_port_arbiter: RTL

- Shares a single memory-controller port (command, write-data and read-data FIFOs) among the six engine DMA ports.
  - p0 and p1 are write ports (engine to memory).
  - p2 to p5 are read ports (memory to engine).
- Round-robin arbitration over level requests; each grant moves exactly one burst of BURST_LEN 16-bit words.
- Sits between the engine and the memory interface; drives the engine-side handshakes dma_pN_ib_re / dma_pN_ob_we and dma_pN_ob_data.

---
 rtl/dma_port_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dma_port_arbiter.sv
// Round-robin arbiter sharing one memory-controller port among two write
// and four read DMA ports; each grant moves one burst of BURST_LEN words.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | sample requests, pick next port from rr_ptr
// S_WR_DATA | strobe engine buffer, push returned words into write FIFO
// S_WR_CMD  | hold write command until the command FIFO accepts it
// S_RD_CMD  | hold read command until the command FIFO accepts it
// S_RD_DATA | pop read FIFO, forward each word to the granted read port
// S_DONE    | pulse port_done, advance rr_ptr past the served port

module dma_port_arbiter #(
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            port_req,
    input  logic [6*ADDR_W-1:0]   port_addr,
    output logic [5:0]            port_done,
    output logic [1:0]            ib_re,
    input  logic [2*16-1:0]       ib_data,
    input  logic [1:0]            ib_valid,
    output logic [3:0]            ob_we,
    output logic [15:0]           ob_data,
    output logic                  mem_cmd_en,
    output logic [2:0]            mem_cmd_instr,
    output logic [ADDR_W-1:0]     mem_cmd_addr,
    output logic [5:0]            mem_cmd_bl,
    input  logic                  mem_cmd_full,
    output logic                  mem_wr_en,
    output logic [15:0]           mem_wr_data,
    input  logic                  mem_wr_full,
    output logic                  mem_rd_en,
    input  logic [15:0]           mem_rd_data,
    input  logic                  mem_rd_empty
);

    localparam logic [5:0] BL6 = 6'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_DATA, S_WR_CMD, S_RD_CMD, S_RD_DATA, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          grant_q, grant_d;
    logic [2:0]          rr_q, rr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [5:0]          issued_q, issued_d;
    logic [5:0]          received_q, received_d;
    logic [5:0]          popped_q, popped_d;
    logic [3:0]          ob_we_q, ob_we_d;
    logic [15:0]         ob_data_q, ob_data_d;

    logic                found;
    logic [2:0]          pick;
    logic [3:0]          idx;

    // Rotating priority scan starting at rr_q, wrapping modulo 6.
    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        idx   = 4'd0;
        for (int i = 0; i < 6; i++) begin
            idx = {1'b0, rr_q} + 4'(i);
            if (idx >= 4'd6) idx = idx - 4'd6;
            if (!found && port_req[idx[2:0]]) begin
                found = 1'b1;
                pick  = idx[2:0];
            end
        end
    end

    logic       wr_sel;
    logic [2:0] rd_idx;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_d          = rr_q;
        addr_d        = addr_q;
        issued_d      = issued_q;
        received_d    = received_q;
        popped_d      = popped_q;
        ob_we_d       = 4'b0000;
        ob_data_d     = ob_data_q;
        wr_sel        = grant_q[0];
        rd_idx        = grant_q - 3'd2;
        ib_re         = 2'b00;
        port_done     = 6'b000000;
        mem_cmd_en    = 1'b0;
        mem_cmd_instr = 3'b000;
        mem_cmd_addr  = '0;
        mem_cmd_bl    = 6'b000000;
        mem_wr_en     = 1'b0;
        mem_wr_data   = 16'h0000;
        mem_rd_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d    = pick;
                    addr_d     = port_addr[int'(pick)*ADDR_W +: ADDR_W];
                    issued_d   = 6'd0;
                    received_d = 6'd0;
                    popped_d   = 6'd0;
                    state_d    = (pick < 3'd2) ? S_WR_DATA : S_RD_CMD;
                end
            end
            S_WR_DATA: begin
                if (issued_q < BL6 && !mem_wr_full) begin
                    ib_re[wr_sel] = 1'b1;
                    issued_d      = issued_q + 6'd1;
                end
                // Words already strobed are pushed even if the FIFO reports
                // full; it is deep enough to hold a whole burst.
                if (ib_valid[wr_sel] && received_q < BL6) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = ib_data[int'(wr_sel)*16 +: 16];
                    received_d  = received_q + 6'd1;
                end
                if (received_d == BL6) state_d = S_WR_CMD;
            end
            S_WR_CMD, S_RD_CMD: begin
                mem_cmd_en    = 1'b1;
                mem_cmd_instr = (state_q == S_RD_CMD) ? 3'b001 : 3'b000;
                mem_cmd_addr  = addr_q;
                mem_cmd_bl    = BL6 - 6'd1;
                if (!mem_cmd_full) begin
                    state_d  = (state_q == S_RD_CMD) ? S_RD_DATA : S_DONE;
                    popped_d = 6'd0;
                end
            end
            S_RD_DATA: begin
                if (popped_q < BL6 && !mem_rd_empty) begin
                    mem_rd_en           = 1'b1;
                    popped_d            = popped_q + 6'd1;
                    ob_we_d[rd_idx[1:0]] = 1'b1;
                    ob_data_d           = mem_rd_data;
                end
                // popped_q reaches BL6 in the cycle the last ob_we is driven.
                if (popped_q == BL6) state_d = S_DONE;
            end
            S_DONE: begin
                port_done[grant_q] = 1'b1;
                rr_d    = (grant_q == 3'd5) ? 3'd0 : grant_q + 3'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            grant_q    <= 3'd0;
            rr_q       <= 3'd0;
            addr_q     <= '0;
            issued_q   <= 6'd0;
            received_q <= 6'd0;
            popped_q   <= 6'd0;
            ob_we_q    <= 4'b0000;
            ob_data_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            addr_q     <= addr_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            popped_q   <= popped_d;
            ob_we_q    <= ob_we_d;
            ob_data_q  <= ob_data_d;
        end
    end

    assign ob_we   = ob_we_q;
    assign ob_data = ob_data_q;

endmodule
